// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: single-clock UART transmitter with an internal baud counter and a transmit FIFO.
// Optional macro UART_TX_PARITY_EN inserts an even-parity bit between the data and stop bits.
module uart_tx_fifo #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned MSB_FIRST    = 1
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          wr_en,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          TxD,
  output logic                          busy,
  output logic                          trans_done
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_W);

  localparam logic [LVL_W-1:0] DEPTH_L   = LVL_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] RELOAD    = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
`endif

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              overflow_q, overflow_d;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  baud_q, baud_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] word_q, word_d;

  logic              push, pop, bit_end;
  logic [IDX_W-1:0]  bit_sel;

  assign full     = (level_q == DEPTH_L);
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign overflow = overflow_q;

  // Writes are judged against the registered full flag, so a same-cycle pop never rescues a write.
  assign push    = wr_en && !full;
  assign pop     = (state_q == S_IDLE) && !empty;
  assign bit_end = (baud_q == '0);
  assign bit_sel = (MSB_FIRST != 0) ? (LAST_IDX - idx_q) : idx_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q | (wr_en & full);
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      level_d = level_q + LVL_W'(1);
    else if (!push && pop) level_d = level_q - LVL_W'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= S_IDLE;
      baud_q     <= '0;
      idx_q      <= '0;
      word_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      baud_q     <= baud_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = bit_end ? RELOAD : baud_q - CNT_W'(1);
    idx_d   = idx_q;
    word_d  = word_q;
    unique case (state_q)
      S_IDLE: begin
        baud_d = baud_q;
        if (pop) begin
          word_d  = mem_q[rd_ptr_q];
          baud_d  = RELOAD;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          idx_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          idx_d   = '0;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        // idx_q doubles as the stop-bit counter when STOP_BITS is 2.
        if (bit_end) begin
          if (idx_q == STOP_LAST) begin
            idx_d   = '0;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    TxD        = 1'b1;
    busy       = (state_q != S_IDLE);
    trans_done = 1'b0;
    unique case (state_q)
      S_IDLE:   TxD = 1'b1;
      S_START:  TxD = 1'b0;
      S_DATA:   TxD = word_q[bit_sel];
`ifdef UART_TX_PARITY_EN
      S_PARITY: TxD = ^word_q;
`endif
      S_STOP:   trans_done = bit_end && (idx_q == STOP_LAST);
      default:  TxD = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: two uart_tx_fifo lanes (MSB-first/1 stop, LSB-first/2 stop) driven by shared
// random writes; a queue-based reference model feeds per-lane frame scoreboards.
module tb_uart_tx_fifo;
  localparam int DW    = 8;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  typedef logic [DW-1:0] word_t;

  logic  clk = 1'b0;
  logic  resetn = 1'b1;
  logic  wr_en = 1'b0;
  word_t wr_data = '0;

  logic          full_w  [2];
  logic          empty_w [2];
  logic          ovf_w   [2];
  logic          txd_w   [2];
  logic          busy_w  [2];
  logic          done_w  [2];
  logic [LW-1:0] level_w [2];

  int tests = 0;
  int fails = 0;
  int unsigned ecount = 0;

  word_t       mq  [2][$];
  word_t       sbw [2][$];
  int unsigned sbs [2][$];
  int unsigned last_pop [2];
  int unsigned free_at  [2];
  bit          have_pop [2];
  bit          m_ovf    [2];
  int          nframes  [2];
  int          ndone    [2];

  uart_tx_fifo #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .STOP_BITS(1), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_data(wr_data),
    .full(full_w[0]), .empty(empty_w[0]), .level(level_w[0]), .overflow(ovf_w[0]),
    .TxD(txd_w[0]), .busy(busy_w[0]), .trans_done(done_w[0]));

  uart_tx_fifo #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .STOP_BITS(2), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_data(wr_data),
    .full(full_w[1]), .empty(empty_w[1]), .level(level_w[1]), .overflow(ovf_w[1]),
    .TxD(txd_w[1]), .busy(busy_w[1]), .trans_done(done_w[1]));

  always #5 clk = ~clk;

  function automatic int frame_len(input int k);
    return (1 + DW + PAR + ((k == 0) ? 1 : 2)) * CPB;
  endfunction

  // Expected line level for bit-time s of a frame carrying w on lane k.
  function automatic logic exp_bit(input int k, input word_t w, input int s);
    int d;
    if (s == 0) return 1'b0;
    if (s <= DW) begin
      d = s - 1;
      return (k == 0) ? w[DW-1-d] : w[d];
    end
    if (PAR == 1 && s == DW + 1) return ^w;
    return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: FIFO as a queue, transmitter as "free again FRAME+1 edges after a pop".
  always @(posedge clk or negedge resetn) begin
    int unsigned sz;
    bit acc;
    word_t w;
    if (!resetn) begin
      for (int k = 0; k < 2; k++) begin
        mq[k].delete(); sbw[k].delete(); sbs[k].delete();
        m_ovf[k] = 0; have_pop[k] = 0; free_at[k] = 0; last_pop[k] = 0;
      end
    end else begin
      ecount++;
      for (int k = 0; k < 2; k++) begin
        sz  = mq[k].size();
        acc = wr_en && (sz < DEPTH);
        if (wr_en && !acc) m_ovf[k] = 1;
        if (ecount >= free_at[k] && sz > 0) begin
          w = mq[k].pop_front();
          sbw[k].push_back(w);
          sbs[k].push_back(ecount);
          last_pop[k] = ecount;
          have_pop[k] = 1;
          free_at[k]  = ecount + frame_len(k) + 1;
        end
        if (acc) mq[k].push_back(wr_data);
      end
    end
  end

  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      for (int k = 0; k < 2; k++) begin
        logic busy_e, done_e;
        int unsigned age;
        age    = ecount - last_pop[k];
        busy_e = have_pop[k] && (age < frame_len(k));
        done_e = have_pop[k] && (age == frame_len(k) - 1);
        chk($sformatf("status lane%0d cyc%0d {level,full,empty,ovf,busy,done}", k, ecount),
            {level_w[k], full_w[k], empty_w[k], ovf_w[k], busy_w[k], done_w[k]},
            {LW'(mq[k].size()), mq[k].size() == DEPTH, mq[k].size() == 0, m_ovf[k], busy_e, done_e});
        if (done_w[k] === 1'b1) ndone[k]++;
      end
    end
  end

  task automatic monitor(input int k);
    word_t w;
    int unsigned st, es;
    int done_at;
    bit ok, aborted, have;
    logic [15:0] act_v, exp_v;
    forever begin
      @(negedge clk);
      if (resetn === 1'b1 && txd_w[k] === 1'b0) begin
        st = ecount; ok = 1; aborted = 0; done_at = -1; act_v = '0; exp_v = '0;
        have = (sbw[k].size() > 0);
        if (have) begin
          w  = sbw[k].pop_front();
          es = sbs[k].pop_front();
        end else begin
          w  = '0;
          es = 0;
        end
        for (int j = 0; j < frame_len(k); j++) begin
          if (j > 0) @(negedge clk);
          if (resetn !== 1'b1) begin
            aborted = 1;
            break;
          end
          if (txd_w[k] !== exp_bit(k, w, j / CPB)) ok = 0;
          if (j % CPB == CPB / 2) begin
            act_v[j/CPB] = txd_w[k];
            exp_v[j/CPB] = exp_bit(k, w, j / CPB);
          end
          if (done_w[k] === 1'b1 && done_at < 0) done_at = j;
        end
        if (!aborted) begin
          nframes[k]++;
          tests++;
          if (!have || !ok || st != es) begin
            fails++;
            $display("FAIL frame lane%0d word %0h: got bits %b start cyc %0d, expected bits %b start cyc %0d%s",
                     k, w, act_v, st, exp_v, es, have ? "" : " (no frame expected)");
          end
          chk($sformatf("done_offset lane%0d", k), done_at, frame_len(k) - 1);
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  task automatic step(input logic en, input word_t d);
    wr_en   = en;
    wr_data = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  function automatic bit all_idle();
    for (int k = 0; k < 2; k++)
      if (mq[k].size() != 0 || sbw[k].size() != 0 || ecount < free_at[k]) return 0;
    return 1;
  endfunction

  task automatic drain();
    int i;
    for (i = 0; i < 4000; i++) begin
      if (all_idle()) break;
      step(1'b0, '0);
    end
    chk("drain_within_budget", i < 4000, 1);
    step(1'b0, '0);
    step(1'b0, '0);
  endtask

  initial begin
    #1_000_000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int cnt, i, lows, thr;
    int f0 [2];
    int d0 [2];
    #1 resetn = 1'b0;
    #2;
    for (int k = 0; k < 2; k++)
      chk($sformatf("reset lane%0d {txd,busy,done,full,empty,level,ovf}", k),
          {txd_w[k], busy_w[k], done_w[k], full_w[k], empty_w[k], level_w[k], ovf_w[k]},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, {LW{1'b0}}, 1'b0});
    @(negedge clk);
    @(negedge clk);
    #2 resetn = 1'b1;
    @(posedge clk);
    #1;

    step(1'b1, 8'hA5); drain();
    step(1'b1, 8'h01); drain();
    step(1'b1, 8'h07); drain();

    for (int k = 0; k < 2; k++) f0[k] = nframes[k];
    cnt = 0;
    for (i = 0; i < 3000 && cnt < 10; i++) begin
      if (mq[0].size() <= 2 && mq[1].size() <= 2) begin
        step(1'b1, word_t'($urandom));
        cnt++;
      end else begin
        step(1'b0, '0);
      end
    end
    chk("wrap_writes_issued", cnt, 10);
    drain();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("wrap_frames lane%0d", k), nframes[k] - f0[k], 10);
      chk($sformatf("wrap_end lane%0d {ovf,empty}", k), {ovf_w[k], empty_w[k]}, 2'b01);
    end

    for (int k = 0; k < 2; k++) begin
      f0[k] = nframes[k];
      d0[k] = ndone[k];
    end
    for (i = 0; i < 6; i++) step(1'b1, word_t'($urandom));
    drain();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("burst_frames lane%0d", k), nframes[k] - f0[k], 5);
      chk($sformatf("burst_done_pulses lane%0d", k), ndone[k] - d0[k], 5);
      chk($sformatf("burst_overflow lane%0d", k), ovf_w[k], 1);
    end

    for (i = 0; i < 3; i++) step(1'b1, word_t'($urandom));
    for (i = 0; i < 50 && busy_w[0] !== 1'b1; i++) step(1'b0, '0);
    chk("busy_before_reset", busy_w[0], 1);
    repeat (CPB * 4 + 1) step(1'b0, '0);
    #2 resetn = 1'b0;
    #1;
    for (int k = 0; k < 2; k++)
      chk($sformatf("async_reset lane%0d {txd,busy,level}", k),
          {txd_w[k], busy_w[k], level_w[k]}, {1'b1, 1'b0, {LW{1'b0}}});
    @(negedge clk);
    @(negedge clk);
    #2 resetn = 1'b1;
    @(posedge clk);
    #1;
    lows = 0;
    repeat (100) begin
      step(1'b0, '0);
      if (txd_w[0] !== 1'b1) lows++;
      if (txd_w[1] !== 1'b1) lows++;
    end
    chk("idle_after_reset_low_cycles", lows, 0);

    for (int ph = 0; ph < 3; ph++) begin
      thr = (ph == 0) ? 10 : (ph == 1) ? 40 : 90;
      for (i = 0; i < 300; i++) step($urandom_range(0, 99) < thr, word_t'($urandom));
    end
    drain();
    for (int k = 0; k < 2; k++)
      chk($sformatf("frames_pending lane%0d", k), sbw[k].size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
